// File: rtl/kbd_event_queue.sv
// ---------------------------------------------------------------------------
// kbd_event_queue
//
// Converts the raw PS/2 scan-code set-2 byte stream into whole key events.
// The stream is parsed in three stages:
//   1. Prefix parser. It tracks the E0 (extended) and F0 (break) prefixes.
//   2. Optional repeat filter. It drops typematic auto-repeat makes of the
//      key that is already held down.
//   3. First-word-fall-through event FIFO with a valid/ready handshake and a
//      sticky overflow flag.
//
// Event format: {ext, brk, code[7:0]}. ext is bit 9 and brk is bit 8.
//
// Ports
//   clk         : clock
//   reset       : asynchronous, active-high reset
//   byte_in     : received PS/2 byte, qualified by byte_valid
//   byte_valid  : one-cycle strobe per received byte
//   ev_valid    : the FIFO holds at least one event; the head is on ev_data
//   ev_data     : head event {ext, brk, code}
//   ev_ready    : consumer accepts the head (pop on ev_valid & ev_ready)
//   ev_count    : number of events currently held
//   overflow    : sticky; an event was lost because the FIFO was full
//   clear_ovf   : synchronous clear of overflow (a same-cycle drop wins)
//
// Parameters
//   DEPTH         : FIFO entries; power of 2, minimum 2
//   REPEAT_FILTER : 1 = drop a repeated make of the held key; 0 = pass all
// ---------------------------------------------------------------------------
module kbd_event_queue #(
    parameter int DEPTH         = 8,
    parameter bit REPEAT_FILTER = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     ev_valid,
    output logic [9:0]               ev_data,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    // -----------------------------------------------------------------------
    // Prefix parser
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0
    } pfx_state_t;

    pfx_state_t r_state;
    pfx_state_t w_state_next;
    logic       w_ev_formed;
    logic [9:0] w_ev;

    // Keyboard housekeeping replies. These are never key codes. They also
    // cancel any partial prefix, so that a stray reply cannot tag the next
    // key as extended or as a break.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ev_formed  = 1'b0;
        w_ev         = {(r_state == ST_E0) || (r_state == ST_E0F0),
                        (r_state == ST_F0) || (r_state == ST_E0F0),
                        byte_in};
        if (byte_valid) begin
            if (byte_in == 8'hE0) begin
                // E0 always restarts a prefix. Any earlier F0 is forgotten.
                w_state_next = ST_E0;
            end else if (byte_in == 8'hF0) begin
                case (r_state)
                    ST_IDLE: w_state_next = ST_F0;
                    ST_E0:   w_state_next = ST_E0F0;
                    default: w_state_next = r_state;
                endcase
            end else if (is_ctrl_byte(byte_in)) begin
                w_state_next = ST_IDLE;
            end else begin
                w_ev_formed  = 1'b1;
                w_state_next = ST_IDLE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Repeat filter
    // -----------------------------------------------------------------------
    logic w_push_req;

    generate
        if (REPEAT_FILTER) begin : g_filter
            logic       r_held_valid;
            logic [8:0] r_held_key;
            logic [8:0] w_key;
            logic       w_match;

            assign w_key      = {w_ev[9], w_ev[7:0]};
            assign w_match    = r_held_valid && (r_held_key == w_key);
            // Breaks always go through. A make is suppressed only when it
            // repeats the key that is already held.
            assign w_push_req = w_ev_formed && (w_ev[8] || !w_match);

            // The held key tracks the keyboard, not the FIFO. It is updated
            // even when the FIFO is full and the push is lost.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_held_valid <= 1'b0;
                    r_held_key   <= '0;
                end else if (w_ev_formed) begin
                    if (!w_ev[8]) begin
                        if (!w_match) begin
                            r_held_key   <= w_key;
                            r_held_valid <= 1'b1;
                        end
                    end else if (w_match) begin
                        r_held_valid <= 1'b0;
                    end
                end
            end
        end else begin : g_no_filter
            assign w_push_req = w_ev_formed;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Event FIFO (first-word fall-through)
    // -----------------------------------------------------------------------
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = ev_ready && !w_empty;
    // When the FIFO is full, a pop in the same cycle frees the head slot in
    // time for the new entry.
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && w_full && !w_pop;

    // Storage has no reset. Slots are only read after they have been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_ev;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // If a clear and a new drop occur in the same cycle, the set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign ev_valid = !w_empty;
    // Forced to zero when empty. This keeps the bus clean out of reset,
    // before any slot has been written.
    assign ev_data  = w_empty ? 10'd0 : r_mem[r_rd_ptr];
    assign ev_count = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_kbd_event_queue.sv
// ---------------------------------------------------------------------------
// tb_kbd_event_queue
//
// Drives two instances from the same byte stream:
//   - index 0: DEPTH=8, REPEAT_FILTER=1
//   - index 1: DEPTH=8, REPEAT_FILTER=0
//
// A behavioural model keeps the following per instance:
//   - prefix flags
//   - the held key
//   - an event queue
//   - the overflow flag
//
// On every falling edge the outputs of both instances are compared against
// that model. Directed tests also compare the delivered event log and a few
// output values against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_kbd_event_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       ev_ready;
    logic       clear_ovf;

    logic       ev_valid_a [2];
    logic [9:0] ev_data_a  [2];
    logic [3:0] ev_count_a [2];
    logic       overflow_a [2];

    always #5 clk = ~clk;

    kbd_event_queue #(.DEPTH(8), .REPEAT_FILTER(1'b1)) u_dut_f (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .ev_valid   (ev_valid_a[0]),
        .ev_data    (ev_data_a[0]),
        .ev_ready   (ev_ready),
        .ev_count   (ev_count_a[0]),
        .overflow   (overflow_a[0]),
        .clear_ovf  (clear_ovf)
    );

    kbd_event_queue #(.DEPTH(8), .REPEAT_FILTER(1'b0)) u_dut_nf (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .ev_valid   (ev_valid_a[1]),
        .ev_data    (ev_data_a[1]),
        .ev_ready   (ev_ready),
        .ev_count   (ev_count_a[1]),
        .overflow   (overflow_a[1]),
        .clear_ovf  (clear_ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0] mq0 [$];
    logic [9:0] mq1 [$];
    logic [9:0] got0 [$];
    logic [9:0] got1 [$];
    bit         ext_p  [2];
    bit         brk_p  [2];
    bit         held_v [2];
    logic [8:0] held_k [2];
    bit         ovf_m  [2];

    function automatic int msize(input int m);
        return (m == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [9:0] mhead(input int m);
        return (m == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic model_step(input int m);
        int         sz;
        bit         pop;
        bit         have;
        bit         take;
        logic [9:0] e;
        sz   = msize(m);
        pop  = ev_ready && (sz > 0);
        have = 1'b0;
        take = 1'b0;
        e    = '0;
        if (byte_valid) begin
            if (byte_in == 8'hE0) begin
                ext_p[m] = 1'b1;
                brk_p[m] = 1'b0;
            end else if (byte_in == 8'hF0) begin
                brk_p[m] = 1'b1;
            end else if (byte_in inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
                ext_p[m] = 1'b0;
                brk_p[m] = 1'b0;
            end else begin
                e        = {ext_p[m], brk_p[m], byte_in};
                have     = 1'b1;
                ext_p[m] = 1'b0;
                brk_p[m] = 1'b0;
            end
        end
        if (have && m == 0) begin
            if (!e[8]) begin
                if (held_v[0] && held_k[0] == {e[9], e[7:0]}) begin
                    have = 1'b0;
                end else begin
                    held_v[0] = 1'b1;
                    held_k[0] = {e[9], e[7:0]};
                end
            end else if (held_v[0] && held_k[0] == {e[9], e[7:0]}) begin
                held_v[0] = 1'b0;
            end
        end
        if (clear_ovf) ovf_m[m] = 1'b0;
        if (have) begin
            if (sz < 8 || pop) take = 1'b1;
            else               ovf_m[m] = 1'b1;
        end
        if (pop) begin
            if (m == 0) void'(mq0.pop_front());
            else        void'(mq1.pop_front());
        end
        if (take) begin
            if (m == 0) mq0.push_back(e);
            else        mq1.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq0.delete();
                mq1.delete();
                for (int m = 0; m < 2; m++) begin
                    ext_p[m]  = 1'b0;
                    brk_p[m]  = 1'b0;
                    held_v[m] = 1'b0;
                    held_k[m] = '0;
                    ovf_m[m]  = 1'b0;
                end
            end else begin
                if (ev_valid_a[0] && ev_ready) got0.push_back(ev_data_a[0]);
                if (ev_valid_a[1] && ev_ready) got1.push_back(ev_data_a[1]);
                model_step(0);
                model_step(1);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int m = 0; m < 2; m++) begin
                    chk($sformatf("ev_valid[%0d]", m), 32'(ev_valid_a[m]), 32'(msize(m) > 0));
                    chk($sformatf("ev_count[%0d]", m), 32'(ev_count_a[m]), 32'(msize(m)));
                    chk($sformatf("overflow[%0d]", m), 32'(overflow_a[m]), 32'(ovf_m[m]));
                    if (msize(m) > 0)
                        chk($sformatf("ev_data[%0d]", m), 32'(ev_data_a[m]), 32'(mhead(m)));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic chk_log(input string name, input int m, input logic [9:0] exp[$]);
        int n;
        n = (m == 0) ? got0.size() : got1.size();
        chk($sformatf("%s_len[%0d]", name, m), 32'(n), 32'(exp.size()));
        for (int i = 0; i < n && i < exp.size(); i++)
            chk($sformatf("%s[%0d][%0d]", name, m, i),
                32'((m == 0) ? got0[i] : got1[i]), 32'(exp[i]));
    endtask

    logic [9:0] exp_q [$];

    initial begin
        reset      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        ev_ready   = 1'b1;
        clear_ovf  = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_ev_valid", 32'(ev_valid_a[m]), 32'd0);
            chk("rst_ev_data",  32'(ev_data_a[m]),  32'd0);
            chk("rst_ev_count", 32'(ev_count_a[m]), 32'd0);
            chk("rst_overflow", 32'(overflow_a[m]), 32'd0);
        end
        idle(2);
        #2 reset = 1'b0;

        // Test 1: a make, then a break
        got0.delete(); got1.delete();
        send(8'h1C); send(8'hF0); send(8'h1C);
        idle(3);
        exp_q = '{10'h01C, 10'h11C};
        chk_log("t1", 0, exp_q);
        chk_log("t1", 1, exp_q);
        chk("t1_count", 32'(ev_count_a[0]), 32'd0);

        // Test 2: extended make/break, and a control byte after a prefix
        got0.delete(); got1.delete();
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hAA); send(8'h16);
        idle(3);
        exp_q = '{10'h275, 10'h375, 10'h016};
        chk_log("t2", 0, exp_q);
        chk_log("t2", 1, exp_q);

        // Test 3: typematic repeat filter
        do_reset();
        got0.delete(); got1.delete();
        send(8'h16); send(8'h16); send(8'h16);
        send(8'hF0); send(8'h16); send(8'h16);
        idle(3);
        exp_q = '{10'h016, 10'h116, 10'h016};
        chk_log("t3", 0, exp_q);
        exp_q = '{10'h016, 10'h016, 10'h016, 10'h116, 10'h016};
        chk_log("t3", 1, exp_q);

        // Test 4: overflow with the consumer stalled, then drain
        ev_ready = 1'b0;
        got0.delete(); got1.delete();
        for (int i = 0; i < 9; i++) send(8'h21 + 8'(i));
        idle(1);
        for (int m = 0; m < 2; m++) begin
            chk("t4_count", 32'(ev_count_a[m]), 32'd8);
            chk("t4_ovf",   32'(overflow_a[m]), 32'd1);
            chk("t4_head",  32'(ev_data_a[m]),  32'h021);
        end
        ev_ready = 1'b1;
        idle(10);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(10'h021 + 10'(i));
        chk_log("t4", 0, exp_q);
        chk_log("t4", 1, exp_q);
        @(negedge clk); clear_ovf = 1'b1;
        @(negedge clk); clear_ovf = 1'b0;
        chk("t4_ovf_clr", 32'(overflow_a[0]), 32'd0);

        // Test 5: full FIFO with push and pop in the same cycle, pointer wrap
        ev_ready = 1'b0;
        got0.delete(); got1.delete();
        for (int i = 0; i < 8; i++) send(8'h31 + 8'(i));
        idle(1);
        chk("t5_full", 32'(ev_count_a[0]), 32'd8);
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            byte_in    = 8'h40 + 8'(i);
            byte_valid = 1'b1;
            ev_ready   = 1'b1;
            @(negedge clk);
            byte_valid = 1'b0;
            ev_ready   = 1'b0;
            chk("t5_count", 32'(ev_count_a[0]), 32'd8);
            chk("t5_ovf",   32'(overflow_a[0]), 32'd0);
        end
        ev_ready = 1'b1;
        idle(12);
        exp_q.delete();
        for (int i = 0; i < 8; i++)  exp_q.push_back(10'h031 + 10'(i));
        for (int i = 0; i < 21; i++) exp_q.push_back(10'h040 + 10'(i));
        chk_log("t5", 0, exp_q);
        chk_log("t5", 1, exp_q);

        // Test 6: asynchronous reset mid-packet with events queued
        ev_ready = 1'b0;
        send(8'h11); send(8'h12); send(8'h13); send(8'hE0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("t6_valid", 32'(ev_valid_a[m]), 32'd0);
            chk("t6_count", 32'(ev_count_a[m]), 32'd0);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        send(8'h1C);
        chk("t6_head",   32'(ev_data_a[0]),  32'h01C);
        chk("t6_valid1", 32'(ev_valid_a[0]), 32'd1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
